// File: rtl/line_burst_adapter.sv
// line_burst_adapter: bridges a 256-bit cache line port to a 64-bit burst
// memory port. Fills gather four beats into line_o; writebacks serialise a
// latched line into four beats. One transfer at a time, beats ascending.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a cache request; write wins over read
// FILL  | read_o high, each resp_i stores burst_i into beat cnt of line_o
// WB    | write_o high, burst_o presents beat cnt of the latched line
// DONE  | resp_o high for one cycle, then back to IDLE
module line_burst_adapter (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] line_i,
   input  logic [31:0]  addr_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic [255:0] line_o,
   output logic         resp_o,
   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  addr_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] WB   = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]   state;
   logic [1:0]   cnt;
   logic [255:0] wb_line;
   logic [31:0]  addr_q;

   // Transfer sequencing, beat counting and line/address capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         wb_line <= '0;
         addr_q  <= '0;
         line_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  wb_line <= line_i;
                  addr_q  <= {addr_i[31:5], 5'b0};
                  cnt     <= 2'd0;
                  state   <= WB;
               end else if (read_i) begin
                  addr_q  <= {addr_i[31:5], 5'b0};
                  cnt     <= 2'd0;
                  state   <= FILL;
               end
            end
            FILL: begin
               if (resp_i) begin
                  line_o[{cnt, 6'b0} +: 64] <= burst_i;
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) state <= DONE;
               end
            end
            WB: begin
               if (resp_i) begin
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd3) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs decoded from registered state only; no input-to-output path.
   always_comb begin
      read_o  = (state == FILL);
      write_o = (state == WB);
      resp_o  = (state == DONE);
      addr_o  = addr_q;
      burst_o = (state == WB) ? wb_line[{cnt, 6'b0} +: 64] : 64'd0;
   end

endmodule
